// File: rtl/fp_add_seq.sv
// rtl/fp_add_seq.sv - multi-cycle binary32 add/sub sequencer with shared lane normalizer
module fp_normalize27 (
  input  logic [26:0] lane,
  input  logic        eff_sub,
  input  logic [8:0]  exp_in,
  input  logic        sticky_in,
  output logic [23:0] mant,
  output logic        g,
  output logic        r,
  output logic        s,
  output logic [8:0]  exp_out,
  output logic        is_zero
);
  logic [4:0]  lz;
  logic [8:0]  lim;
  logic [4:0]  sh;
  logic [26:0] shifted;

  always_comb begin
    lz = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (lane[i]) lz = 5'(25 - i);
    end
  end

  // Left shift is clipped so the exponent never drops below 1 (subnormal floor).
  assign lim     = exp_in - 9'd1;
  assign sh      = !eff_sub ? 5'd0 : ((9'(lz) < lim) ? lz : lim[4:0]);
  assign shifted = lane << sh;
  assign is_zero = (lane == 27'd0) && !sticky_in;

  always_comb begin
    if (lane[26]) begin
      mant    = lane[26:3];
      g       = lane[2];
      r       = lane[1];
      s       = sticky_in | lane[0];
      exp_out = exp_in + 9'd1;
    end else begin
      mant    = shifted[25:2];
      g       = shifted[1];
      r       = shifted[0];
      s       = sticky_in;
      exp_out = exp_in - 9'(sh);
    end
  end
endmodule

module fp_add_seq #(
  parameter int LANE_W = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_nx,
  output logic        flag_nv,
  output logic        flag_zero,
  output logic        busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state, nxt;

  logic [31:0]       a_q, b_q;
  logic              xs, ys, sign_q, eff_sub_q, sticky_q;
  logic [8:0]        xe, ye, exp_q;
  logic [LANE_W-1:0] xl, yl, sum_q;
  logic [23:0]       n_mant;
  logic              n_g, n_r, n_s, n_zero;
  logic [8:0]        n_exp;

  // Unpack decode of the captured operands
  logic [7:0] ea, eb;
  logic       a_nan, b_nan, a_inf, b_inf, is_invalid, is_special;

  assign ea         = a_q[30:23];
  assign eb         = b_q[30:23];
  assign a_nan      = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan      = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf      = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf      = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign is_invalid = a_nan | b_nan | (a_inf & b_inf & (a_q[31] ^ b_q[31]));
  assign is_special = is_invalid | a_inf | b_inf;

  // Align: larger magnitude becomes X, Y is shifted right collecting sticky
  logic              swap, big_s;
  logic [8:0]        big_e, sml_e, d;
  logic [LANE_W-1:0] big_l, sml_l, sml_sh;
  logic              al_sticky;

  assign swap  = {ye, yl} > {xe, xl};
  assign big_s = swap ? ys : xs;
  assign big_e = swap ? ye : xe;
  assign sml_e = swap ? xe : ye;
  assign big_l = swap ? yl : xl;
  assign sml_l = swap ? xl : yl;
  assign d     = big_e - sml_e;

  always_comb begin
    sml_sh    = '0;
    al_sticky = |sml_l;
    if (d < 9'(LANE_W)) begin
      sml_sh    = sml_l >> d;
      al_sticky = |(sml_l & ~({LANE_W{1'b1}} << d));
    end
  end

  // Sticky is borrowed from the lane on subtraction so the G/R/S tail stays exact.
  logic [LANE_W-1:0] add_res;
  assign add_res = eff_sub_q ? (xl - yl - LANE_W'(sticky_q)) : (xl + yl);

  logic [23:0] nm_mant;
  logic        nm_g, nm_r, nm_s, nm_zero;
  logic [8:0]  nm_exp;

  fp_normalize27 u_norm (
    .lane      (sum_q),
    .eff_sub   (eff_sub_q),
    .exp_in    (exp_q),
    .sticky_in (sticky_q),
    .mant      (nm_mant),
    .g         (nm_g),
    .r         (nm_r),
    .s         (nm_s),
    .exp_out   (nm_exp),
    .is_zero   (nm_zero)
  );

  // Round to nearest even and encode
  logic        inc, rnx, subn;
  logic [24:0] m_sum;
  logic [23:0] mr;
  logic [8:0]  er;

  assign inc   = n_g & (n_r | n_s | n_mant[0]);
  assign m_sum = {1'b0, n_mant} + {24'd0, inc};
  assign mr    = m_sum[24] ? 24'h800000 : m_sum[23:0];
  assign er    = n_exp + {8'd0, m_sum[24]};
  assign rnx   = n_g | n_r | n_s;
  assign subn  = ~mr[23];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (in_valid) nxt = S_UNPACK;
      S_UNPACK: nxt = is_special ? S_DONE : S_ALIGN;
      S_ALIGN:  nxt = S_ADD;
      S_ADD:    nxt = S_NORM;
      S_NORM:   nxt = S_ROUND;
      S_ROUND:  nxt = S_DONE;
      S_DONE:   if (out_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;       b_q <= '0;
      xs <= 1'b0;      ys <= 1'b0;       xe <= '0;   ye <= '0;
      xl <= '0;        yl <= '0;         sum_q <= '0; exp_q <= '0;
      sign_q <= 1'b0;  eff_sub_q <= 1'b0; sticky_q <= 1'b0;
      n_mant <= '0;    n_g <= 1'b0;      n_r <= 1'b0; n_s <= 1'b0;
      n_exp <= '0;     n_zero <= 1'b0;
      result <= '0;
      flag_ovf <= 1'b0; flag_unf <= 1'b0; flag_nx <= 1'b0;
      flag_nv <= 1'b0;  flag_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= {b[31] ^ op, b[30:0]};
        end
        S_UNPACK: begin
          if (is_special) begin
            result    <= is_invalid ? 32'h7FC00000 : (a_inf ? a_q : b_q);
            flag_nv   <= is_invalid;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_nx   <= 1'b0;
            flag_zero <= 1'b0;
          end else begin
            xs <= a_q[31];
            ys <= b_q[31];
            xe <= (ea == 8'd0) ? 9'd1 : {1'b0, ea};
            ye <= (eb == 8'd0) ? 9'd1 : {1'b0, eb};
            xl <= {1'b0, ea != 8'd0, a_q[22:0], 2'b00};
            yl <= {1'b0, eb != 8'd0, b_q[22:0], 2'b00};
          end
        end
        S_ALIGN: begin
          xl        <= big_l;
          yl        <= sml_sh;
          xe        <= big_e;
          sticky_q  <= al_sticky;
          eff_sub_q <= xs ^ ys;
          sign_q    <= big_s;
        end
        S_ADD: begin
          sum_q <= add_res;
          exp_q <= xe;
        end
        S_NORM: begin
          n_mant <= nm_mant;
          n_g    <= nm_g;
          n_r    <= nm_r;
          n_s    <= nm_s;
          n_exp  <= nm_exp;
          n_zero <= nm_zero;
        end
        S_ROUND: begin
          flag_nv <= 1'b0;
          if (n_zero) begin
            result    <= {eff_sub_q ? 1'b0 : sign_q, 31'd0};
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_nx   <= 1'b0;
            flag_zero <= 1'b1;
          end else if (er >= 9'd255) begin
            result    <= {sign_q, 8'hFF, 23'd0};
            flag_ovf  <= 1'b1;
            flag_unf  <= 1'b0;
            flag_nx   <= 1'b1;
            flag_zero <= 1'b0;
          end else begin
            result    <= {sign_q, subn ? 8'd0 : er[7:0], mr[22:0]};
            flag_ovf  <= 1'b0;
            flag_unf  <= rnx & subn;
            flag_nx   <= rnx;
            flag_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
endmodule
